// File: rtl/onchip_ram_bist_master.sv
// ---------------------------------------------------------------------------
// onchip_ram_bist_master
//
// Avalon-MM built-in self-test master for the single-port on-chip RAM.
// On start it writes a pattern (incrementing or checkerboard) over a word
// window, reads the window back, and counts mismatches against the same
// pattern regenerated on the fly.
//
// Optional feature macro: ONCHIP_RAM_BIST_FIRST_FAIL_EN
//   defined   -> first mismatching address/readdata of a run are captured
//   undefined -> first_fail_addr / first_fail_data are tied to zero
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset, waiting for start
// WRITE   | one pattern write per cycle, window index 0..len-1
// READ    | one read per cycle, compare trails by one cycle
// DRAIN   | bus idle, last read word is compared
// DONE    | result valid, waiting for the next start
// ---------------------------------------------------------------------------
module onchip_ram_bist_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              pat_sel,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_data,
    output logic [ADDR_W-1:0] address,
    output logic [BE_W-1:0]   byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q,     state_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              pass_q,      pass_d;
    logic [15:0]       err_cnt_q,   err_cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [BE_W-1:0]   be_q,        be_d;
    logic              cs_q,        cs_d;
    logic              wr_q,        wr_d;
    logic [DATA_W-1:0] pat_q,       pat_d;
    logic              clken_q;

    // Window parameters latched at start; idx counts through the window.
    logic [ADDR_W-1:0] base_q,      base_d;
    logic [ADDR_W-1:0] last_q,      last_d;
    logic              pat_sel_q,   pat_sel_d;
    logic [DATA_W-1:0] seed_q,      seed_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;

    // One-stage compare pipeline matching the RAM read latency.
    logic              cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0] exp_q,       exp_d;

    logic              mismatch;
    logic [DATA_W-1:0] next_pat;
    logic              at_last;

    assign mismatch = cmp_valid_q && (readdata != exp_q);
    assign next_pat = pat_sel_q ? ~pat_q : (pat_q + DATA_W'(1));
    assign at_last  = (idx_q == last_q);

    // Next-state logic: sequencing, bus strobes, pattern generator and compare.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        addr_d      = addr_q;
        cs_d        = cs_q;
        wr_d        = wr_q;
        pat_d       = pat_q;
        base_d      = base_q;
        last_d      = last_q;
        pat_sel_d   = pat_sel_q;
        seed_d      = seed_q;
        idx_d       = idx_q;
        cmp_valid_d = 1'b0;
        exp_d       = exp_q;

        if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d    = base;
                    pat_sel_d = pat_sel;
                    seed_d    = seed;
                    // len == 2^ADDR_W has zero low bits, so this wraps to the top index.
                    last_d    = len[ADDR_W-1:0] - ADDR_W'(1);
                    idx_d     = '0;
                    err_cnt_d = '0;
                    if (len == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        cs_d    = 1'b0;
                        wr_d    = 1'b0;
                    end else begin
                        state_d = S_WRITE;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = base;
                        pat_d   = seed;
                    end
                end
            end
            S_WRITE: begin
                if (at_last) begin
                    // Restart address and pattern for the read-back pass.
                    state_d = S_READ;
                    wr_d    = 1'b0;
                    idx_d   = '0;
                    addr_d  = base_q;
                    pat_d   = seed_q;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    pat_d   = next_pat;
                end
            end
            S_READ: begin
                cmp_valid_d = 1'b1;
                exp_d       = pat_q;
                if (at_last) begin
                    state_d = S_DRAIN;
                    cs_d    = 1'b0;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    pat_d   = next_pat;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_cnt_d == 16'd0);
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                cs_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase

        be_d = {BE_W{cs_d}};
    end

    // State, bus and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            pat_q       <= '0;
            base_q      <= '0;
            last_q      <= '0;
            pat_sel_q   <= 1'b0;
            seed_q      <= '0;
            idx_q       <= '0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            pat_q       <= pat_d;
            base_q      <= base_d;
            last_q      <= last_d;
            pat_sel_q   <= pat_sel_d;
            seed_q      <= seed_d;
            idx_q       <= idx_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
        end
    end

    // RAM clock enable drops only while reset is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clken_q <= 1'b0;
        end else begin
            clken_q <= 1'b1;
        end
    end

`ifdef ONCHIP_RAM_BIST_FIRST_FAIL_EN
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [ADDR_W-1:0] ff_addr_q;
    logic [DATA_W-1:0] ff_data_q;

    // Capture the first mismatch of a run; err_cnt_q is still zero on that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_addr_q <= '0;
            ff_addr_q  <= '0;
            ff_data_q  <= '0;
        end else begin
            if (state_q == S_READ) begin
                cmp_addr_q <= addr_q;
            end
            if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
                ff_addr_q <= '0;
                ff_data_q <= '0;
            end else if (mismatch && (err_cnt_q == 16'd0)) begin
                ff_addr_q <= cmp_addr_q;
                ff_data_q <= readdata;
            end
        end
    end

    assign first_fail_addr = ff_addr_q;
    assign first_fail_data = ff_data_q;
`else
    assign first_fail_addr = '0;
    assign first_fail_data = '0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign address    = addr_q;
    assign byteenable = be_q;
    assign chipselect = cs_q;
    assign write      = wr_q;
    assign writedata  = pat_q;
    assign clken      = clken_q;

endmodule

// File: tb/tb_onchip_ram_bist_master.sv
// ---------------------------------------------------------------------------
// Testbench for onchip_ram_bist_master: behavioural RAM with fault injection,
// a window/pattern reference model, and per-scenario tasks.
// ---------------------------------------------------------------------------
module tb_onchip_ram_bist_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [12:0] base;
    logic [13:0] len;
    logic        pat_sel;
    logic [63:0] seed;
    logic        busy, done, pass, chipselect, write, clken;
    logic [15:0] err_cnt;
    logic [12:0] first_fail_addr, address;
    logic [63:0] first_fail_data, writedata, readdata;
    logic [7:0]  byteenable;

    onchip_ram_bist_master dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base(base), .len(len),
        .pat_sel(pat_sel), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail_addr(first_fail_addr),
        .first_fail_data(first_fail_data), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .writedata(writedata), .clken(clken), .readdata(readdata)
    );

    always #5 clk = ~clk;

    wire [183:0] all_out = {busy, done, pass, err_cnt, first_fail_addr, first_fail_data,
                            address, byteenable, chipselect, write, writedata, clken};

    // ---------------- RAM model with fault injection ----------------
    logic [63:0] mem [0:8191];
    int          fault_mode = 0;     // 0 none, 1 flip bit 0 at fault_addr, 2 constant word
    logic [12:0] fault_addr = '0;
    logic [63:0] const_word = '0;

    function automatic logic [63:0] ram_out(input logic [12:0] a);
        logic [63:0] v;
        v = mem[a];
        if (fault_mode == 1 && a == fault_addr) v = v ^ 64'd1;
        if (fault_mode == 2) v = const_word;
        return v;
    endfunction

    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        readdata <= ram_out(address);
    end

    // ---------------- reference model ----------------
    int          r_base, r_len;
    bit          r_pat;
    logic [63:0] r_seed;

    function automatic logic [12:0] a_of(input int i);
        logic [12:0] b13, i13;
        b13 = r_base[12:0];
        i13 = i[12:0];
        return b13 + i13;
    endfunction

    function automatic logic [63:0] d_of(input int i);
        if (r_pat) return (i % 2 == 1) ? ~r_seed : r_seed;
        return r_seed + 64'(i);
    endfunction

    int          ref_err;
    logic [12:0] ref_ffa;
    logic [63:0] ref_ffd;

    task automatic ref_result();
        int cnt;
        logic [63:0] rv;
        cnt = 0; ref_ffa = '0; ref_ffd = '0;
        for (int i = 0; i < r_len; i++) begin
            rv = d_of(i);
            if (fault_mode == 1 && a_of(i) == fault_addr) rv = rv ^ 64'd1;
            if (fault_mode == 2) rv = const_word;
            if (rv != d_of(i)) begin
                if (cnt == 0) begin ref_ffa = a_of(i); ref_ffd = rv; end
                cnt++;
            end
        end
        ref_err = (cnt > 65535) ? 65535 : cnt;
    endtask

    // ---------------- run driver / observer ----------------
    int          pass_cnt = 0, total_cnt = 0;
    int          obs_dev, obs_done_cyc;
    string       dev_note;
    logic [15:0] obs_err;
    logic        obs_pass;
    logic [12:0] obs_ffa;
    logic [63:0] obs_ffd;

    task automatic run_bist(input int b, input int l, input bit p, input logic [63:0] s,
                            input int mid_k);
        int  last, idx;
        bit  e_cs, e_wr, e_busy, e_done;
        r_base = b; r_len = l; r_pat = p; r_seed = s;
        obs_dev = 0; obs_done_cyc = 0; dev_note = "none";
        last = (l == 0) ? 1 : 2 * l + 2;
        @(negedge clk);
        start = 1'b1; base = b[12:0]; len = l[13:0]; pat_sel = p; seed = s;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                base = 13'($urandom); len = 14'($urandom); pat_sel = 1'($urandom);
                seed = {$urandom, $urandom};
            end
            if (k == mid_k) start = 1'b1;
            else if (k == mid_k + 1) start = 1'b0;
            e_cs   = (l > 0) && (k <= 2 * l);
            e_wr   = (l > 0) && (k <= l);
            e_busy = (l > 0) && (k <= 2 * l + 1);
            e_done = (k == last);
            idx    = (k <= l) ? k - 1 : k - l - 1;
            if (chipselect !== e_cs || write !== e_wr || busy !== e_busy || done !== e_done ||
                byteenable !== (e_cs ? 8'hFF : 8'h00) || clken !== 1'b1 ||
                (e_cs && address !== a_of(idx)) || (e_wr && writedata !== d_of(idx))) begin
                if (obs_dev == 0)
                    dev_note = $sformatf("cycle %0d cs=%b wr=%b busy=%b done=%b addr=%0d wd=%h",
                                         k, chipselect, write, busy, done, address, writedata);
                obs_dev++;
            end
            if (done === 1'b1 && obs_done_cyc == 0) obs_done_cyc = k;
        end
        start = 1'b0;
        obs_err = err_cnt; obs_pass = pass; obs_ffa = first_fail_addr; obs_ffd = first_fail_data;
        ref_result();
    endtask

    // Common post-run comparisons are written out in each scenario task.

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; base = '0; len = '0; pat_sel = 1'b0; seed = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h required 0", all_out);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({clken, busy, done, chipselect} !== 4'b1000)
            $display("FAIL reset_release: clken/busy/done/cs=%b required 1000",
                     {clken, busy, done, chipselect});
        else pass_cnt++;
    endtask

    task automatic test_incrementing();
        fault_mode = 0;
        run_bist(0, 4, 1'b0, 64'd0, 0);
        total_cnt++;
        if (obs_dev !== 0) $display("FAIL incr_bus: %0d deviations, first %s, required 0", obs_dev, dev_note);
        else pass_cnt++;
        total_cnt++;
        if (obs_done_cyc !== 10) $display("FAIL incr_done_cycle: got %0d required 10", obs_done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (obs_err !== 16'd0 || obs_pass !== 1'b1)
            $display("FAIL incr_result: err=%0d pass=%b required 0/1", obs_err, obs_pass);
        else pass_cnt++;
    endtask

    task automatic test_checkerboard_wrap();
        fault_mode = 0;
        run_bist(8190, 4, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 0);
        total_cnt++;
        if (obs_dev !== 0) $display("FAIL ckb_bus: %0d deviations, first %s, required 0", obs_dev, dev_note);
        else pass_cnt++;
        total_cnt++;
        if (obs_err !== 16'd0 || obs_pass !== 1'b1)
            $display("FAIL ckb_result: err=%0d pass=%b required 0/1", obs_err, obs_pass);
        else pass_cnt++;
    endtask

    task automatic test_bit_flip();
        fault_mode = 1; fault_addr = 13'd5;
        run_bist(0, 16, 1'b0, 64'd0, 0);
        total_cnt++;
        if (obs_err !== 16'(ref_err) || obs_pass !== 1'b0)
            $display("FAIL flip_result: err=%0d pass=%b required %0d/0", obs_err, obs_pass, ref_err);
        else pass_cnt++;
`ifdef ONCHIP_RAM_BIST_FIRST_FAIL_EN
        total_cnt++;
        if (obs_ffa !== 13'd5 || obs_ffd !== 64'h4)
            $display("FAIL flip_first_fail: addr=%0d data=%h required 5/4", obs_ffa, obs_ffd);
        else pass_cnt++;
`else
        total_cnt++;
        if (obs_ffa !== '0 || obs_ffd !== '0)
            $display("FAIL flip_first_fail_tied: addr=%0d data=%h required 0/0", obs_ffa, obs_ffd);
        else pass_cnt++;
`endif
        fault_mode = 0;
    endtask

    task automatic test_len_zero();
        fault_mode = 0;
        run_bist(77, 0, 1'b0, 64'd0, 0);
        total_cnt++;
        if (obs_dev !== 0) $display("FAIL len0_bus: %0d deviations, first %s, required 0", obs_dev, dev_note);
        else pass_cnt++;
        total_cnt++;
        if (obs_done_cyc !== 1) $display("FAIL len0_done_cycle: got %0d required 1", obs_done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (obs_err !== 16'd0 || obs_pass !== 1'b1 || obs_ffa !== '0 || obs_ffd !== '0)
            $display("FAIL len0_result: err=%0d pass=%b ffa=%0d ffd=%h required 0/1/0/0",
                     obs_err, obs_pass, obs_ffa, obs_ffd);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        fault_mode = 0;
        run_bist(300, 8, 1'b0, {$urandom, $urandom}, 5);
        total_cnt++;
        if (obs_dev !== 0) $display("FAIL ignore_bus: %0d deviations, first %s, required 0", obs_dev, dev_note);
        else pass_cnt++;
        total_cnt++;
        if (obs_done_cyc !== 18) $display("FAIL ignore_done_cycle: got %0d required 18", obs_done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        fault_mode = 0;
        for (int n = 0; n < 2; n++) begin
            run_bist(1000 + n, 3 + 2 * n, n[0], {$urandom, $urandom}, 0);
            total_cnt++;
            if (obs_dev !== 0 || obs_done_cyc !== 2 * r_len + 2)
                $display("FAIL b2b_run%0d: deviations=%0d done_cycle=%0d required 0/%0d (%s)",
                         n, obs_dev, obs_done_cyc, 2 * r_len + 2, dev_note);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int b, l;
        for (int n = 0; n < 6; n++) begin
            l = $urandom_range(1, 40);
            b = (n % 2 == 0) ? int'($urandom_range(0, 8191)) : 8192 - int'($urandom_range(1, 10));
            fault_mode = int'($urandom_range(0, 1));
            r_base = b;
            fault_addr = (n == 3) ? 13'(b + l + 5) : a_of(int'($urandom_range(0, l - 1)));
            run_bist(b, l, 1'($urandom), {$urandom, $urandom}, 0);
            total_cnt++;
            if (obs_dev !== 0 || obs_done_cyc !== 2 * l + 2)
                $display("FAIL rand%0d_bus: deviations=%0d done_cycle=%0d required 0/%0d (%s)",
                         n, obs_dev, obs_done_cyc, 2 * l + 2, dev_note);
            else pass_cnt++;
            total_cnt++;
            if (obs_err !== 16'(ref_err) || obs_pass !== (ref_err == 0))
                $display("FAIL rand%0d_result: err=%0d pass=%b required %0d/%b",
                         n, obs_err, obs_pass, ref_err, ref_err == 0);
            else pass_cnt++;
`ifdef ONCHIP_RAM_BIST_FIRST_FAIL_EN
            total_cnt++;
            if (obs_ffa !== ref_ffa || obs_ffd !== ref_ffd)
                $display("FAIL rand%0d_first_fail: addr=%0d data=%h required %0d/%h",
                         n, obs_ffa, obs_ffd, ref_ffa, ref_ffd);
            else pass_cnt++;
`endif
        end
        fault_mode = 0;
    endtask

    task automatic test_abort_reset();
        int bad;
        @(negedge clk);
        start = 1'b1; base = 13'd100; len = 14'd8; pat_sel = 1'b0; seed = 64'd9;
        @(negedge clk); start = 1'b0;     // cycle 1
        @(negedge clk);                   // cycle 2
        @(negedge clk);                   // cycle 3
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (all_out !== '0) $display("FAIL abort_outputs: got %h required 0", all_out);
        else pass_cnt++;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (chipselect !== 1'b0 || clken !== 1'b0) bad++;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (chipselect !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL abort_idle: %0d bad cycles required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (clken !== 1'b1) $display("FAIL abort_clken: got %b required 1", clken);
        else pass_cnt++;
    endtask

    task automatic test_full_window();
        logic [63:0] s;
        s = {$urandom, $urandom};
        fault_mode = 2; const_word = s - 64'd1;
        run_bist(4321, 8192, 1'b0, s, 0);
        total_cnt++;
        if (obs_err !== 16'd8192 || obs_err !== 16'(ref_err) || obs_pass !== 1'b0)
            $display("FAIL full_window_result: err=%0d pass=%b required 8192/0", obs_err, obs_pass);
        else pass_cnt++;
        total_cnt++;
        if (obs_done_cyc !== 2 * 8192 + 2)
            $display("FAIL full_window_done_cycle: got %0d required %0d", obs_done_cyc, 2 * 8192 + 2);
        else pass_cnt++;
`ifdef ONCHIP_RAM_BIST_FIRST_FAIL_EN
        total_cnt++;
        if (obs_ffa !== 13'd4321 || obs_ffd !== const_word)
            $display("FAIL full_window_first_fail: addr=%0d data=%h required 4321/%h",
                     obs_ffa, obs_ffd, const_word);
        else pass_cnt++;
`endif
        fault_mode = 0;
    endtask

    initial begin
        test_reset();
        test_incrementing();
        test_checkerboard_wrap();
        test_bit_flip();
        test_len_zero();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_abort_reset();
        test_full_window();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
